// File: rtl/tdm_mux.sv
// tdm_mux: 4-channel round-robin time-division multiplexer with per-channel holding registers
module tdm_mux #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*WIDTH-1:0] mux_in,
  input  logic [3:0]         mux_in_valid,
  output logic [3:0]         mux_in_ready,
  output logic [WIDTH-1:0]   mux_out,
  output logic [1:0]         mux_out_select,
  output logic               mux_out_valid,
  input  logic               mux_out_ready
);
  typedef enum logic {EMPTY, FULL} slot_t;
  typedef enum logic {IDLE, VALID} out_t;
  slot_t            slot [4];
  logic [WIDTH-1:0] hold [4];
  out_t             out_state;
  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             grant_found;
  logic             load;
  assign mux_out_valid = out_state == VALID;
  assign load = !mux_out_valid || mux_out_ready;
  always_comb begin
    for (int i = 0; i < 4; i++) mux_in_ready[i] = slot[i] == EMPTY;
  end
  // scan starts just after the last winner so it drops to lowest priority
  always_comb begin
    grant_found = 1'b0;
    grant = last_grant;
    idx = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!grant_found && slot[idx] == FULL) begin
        grant_found = 1'b1;
        grant = idx;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        slot[i] <= EMPTY;
        hold[i] <= '0;
      end
      out_state <= IDLE;
      mux_out <= '0;
      mux_out_select <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load && grant_found && grant == 2'(i)) slot[i] <= EMPTY;
        else if (mux_in_valid[i] && slot[i] == EMPTY) begin
          slot[i] <= FULL;
          hold[i] <= mux_in[i*WIDTH +: WIDTH];
        end
      end
      if (load) begin
        if (grant_found) begin
          out_state <= VALID;
          mux_out <= hold[grant];
          mux_out_select <= grant;
          last_grant <= grant;
        end else out_state <= IDLE;
      end
    end
  end
endmodule
